// File: rtl/rat_int_ctrl.sv
// Purpose: RAT MCU interrupt controller; syncs/edge-detects sources, masks, arbitrates, handshakes with CU.
// Latency: source rise sampled at edge 0 -> pending at edge 2 -> INT_REQ at edge 3; RD_DATA combinational.
// Backpressure: INT_REQ is held with a frozen INT_ID until INT_ACK or until nothing stays eligible.
module rat_int_ctrl #(
    parameter int          N_SRC   = 4,
    parameter logic [7:0]  MASK_ID = 8'hE0,
    parameter logic [7:0]  PEND_ID = 8'hE1,
    parameter logic [7:0]  STAT_ID = 8'hE2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [N_SRC-1:0] INT_SRC,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    input  logic             I_SET,
    input  logic             I_CLR,
    input  logic             INT_ACK,
    output logic             INT_REQ,
    output logic [2:0]       INT_ID,
    output logic             I_FLAG,
    output logic [7:0]       RD_DATA
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic               req_next;
    logic [2:0]         id_next;

    logic [N_SRC-1:0]   sync1, sync2, src_d;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   pending, mask;
    logic [N_SRC-1:0]   eligible;
    logic [N_SRC-1:0]   pend_clr;
    logic [N_SRC-1:0]   id_onehot;
    logic [2:0]         winner;
    logic               ack_ok;
    logic               mask_wr, pend_wr;
    logic [7:0]         mask_ext, pend_ext;
    logic               unused_out_port;

    // Upper write-data bits are not needed when fewer than 8 sources exist.
    assign unused_out_port = ^OUT_PORT;

    assign mask_wr = IO_STRB && (PORT_ID == MASK_ID);
    assign pend_wr = IO_STRB && (PORT_ID == PEND_ID);
    // An acknowledge only counts while a request is actually outstanding.
    assign ack_ok  = INT_ACK && (state == REQ);

    // Two-flop synchroniser followed by a delay flop used for rising-edge detection.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '0;
            sync2 <= '0;
            src_d <= '0;
        end else begin
            sync1 <= INT_SRC;
            sync2 <= sync1;
            src_d <= sync2;
        end
    end

    // A held level produces a single rise pulse; a new edge is required to re-arm.
    assign rise = sync2 & ~src_d;

    // One-hot of the frozen id and the combined clear vector for the pending register.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot[i] = (INT_ID == 3'(i));
        end
        pend_clr = '0;
        if (ack_ok) begin
            pend_clr = pend_clr | id_onehot;
        end
        if (pend_wr) begin
            pend_clr = pend_clr | OUT_PORT[N_SRC-1:0];
        end
    end

    // Pending register: a new edge wins over any clear in the same cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | rise;
        end
    end

    // Software mask register, 1 = source enabled.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mask <= '0;
        end else if (mask_wr) begin
            mask <= OUT_PORT[N_SRC-1:0];
        end
    end

    // Global I flag: clear (CLI or interrupt entry) dominates set.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            I_FLAG <= 1'b0;
        end else if (I_CLR || ack_ok) begin
            I_FLAG <= 1'b0;
        end else if (I_SET) begin
            I_FLAG <= 1'b1;
        end
    end

    assign eligible = I_FLAG ? (pending & mask) : '0;

    // Fixed-priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        winner = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    // FSM state and registered request/id outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            INT_REQ <= 1'b0;
            INT_ID  <= 3'd0;
        end else begin
            state   <= state_next;
            INT_REQ <= req_next;
            INT_ID  <= id_next;
        end
    end

    // FSM next state: request, wait for ack or withdraw, then hold until RETIE.
    always_comb begin
        state_next = state;
        req_next   = INT_REQ;
        id_next    = INT_ID;
        case (state)
            IDLE: begin
                req_next = 1'b0;
                if (|eligible) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                    id_next    = winner;
                end
            end
            REQ: begin
                // INT_ID stays frozen here so a later, higher-priority source cannot pre-empt.
                if (INT_ACK) begin
                    state_next = SERVICE;
                    req_next   = 1'b0;
                end else if (~|eligible) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            SERVICE: begin
                // No nesting: nothing is requested until the handler returns.
                req_next = 1'b0;
                if (I_SET) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    // Zero-extended register views for the read mux.
    always_comb begin
        mask_ext = '0;
        pend_ext = '0;
        mask_ext[N_SRC-1:0] = mask;
        pend_ext[N_SRC-1:0] = pending;
    end

    // Combinational read data for the IN_PORT mux.
    always_comb begin
        RD_DATA = 8'h00;
        if (PORT_ID == MASK_ID) begin
            RD_DATA = mask_ext;
        end else if (PORT_ID == PEND_ID) begin
            RD_DATA = pend_ext;
        end else if (PORT_ID == STAT_ID) begin
            RD_DATA = {I_FLAG, state, 2'b00, INT_ID};
        end
    end

endmodule

// File: tb/tb_rat_int_ctrl.sv
module tb_rat_int_ctrl;

    localparam logic [7:0] MASK_ID = 8'hE0;
    localparam logic [7:0] PEND_ID = 8'hE1;
    localparam logic [7:0] STAT_ID = 8'hE2;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] INT_SRC;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic       I_SET;
    logic       I_CLR;
    logic       INT_ACK;
    logic       INT_REQ;
    logic [2:0] INT_ID;
    logic       I_FLAG;
    logic [7:0] RD_DATA;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    rat_int_ctrl #(
        .N_SRC   (4),
        .MASK_ID (MASK_ID),
        .PEND_ID (PEND_ID),
        .STAT_ID (STAT_ID)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .INT_SRC  (INT_SRC),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .I_SET    (I_SET),
        .I_CLR    (I_CLR),
        .INT_ACK  (INT_ACK),
        .INT_REQ  (INT_REQ),
        .INT_ID   (INT_ID),
        .I_FLAG   (I_FLAG),
        .RD_DATA  (RD_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] id, input logic [7:0] expv);
        PORT_ID = id;
        #1;
        chk(tag, RD_DATA, expv);
        PORT_ID = 8'h00;
    endtask

    task automatic io_write(input logic [7:0] id, input logic [7:0] data);
        PORT_ID  = id;
        OUT_PORT = data;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
    endtask

    task automatic pulse_set();
        I_SET = 1'b1;
        tick();
        I_SET = 1'b0;
    endtask

    task automatic pulse_ack();
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
    endtask

    task automatic src_pulse(input logic [3:0] bits);
        INT_SRC = INT_SRC | bits;
        tick(2);
        INT_SRC = INT_SRC & ~bits;
    endtask

    // Waits (bounded) for a request, then compares INT_ID with the oldest scoreboard entry.
    task automatic wait_req(input string tag);
        int n;
        int expv;
        n = 0;
        while (INT_REQ !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {7'd0, INT_REQ}, 8'h01);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s observed=request expected=none queued", tag);
        end else begin
            expv = exp_q.pop_front();
            chk({tag, "_id"}, {5'd0, INT_ID}, 8'(expv));
        end
    endtask

    initial begin
        RESET_N  = 1'b0;
        INT_SRC  = 4'h0;
        PORT_ID  = 8'h00;
        OUT_PORT = 8'h00;
        IO_STRB  = 1'b0;
        I_SET    = 1'b0;
        I_CLR    = 1'b0;
        INT_ACK  = 1'b0;
        #2;
        chk("rst_req",   {7'd0, INT_REQ}, 8'h00);
        chk("rst_id",    {5'd0, INT_ID},  8'h00);
        chk("rst_iflag", {7'd0, I_FLAG},  8'h00);
        rd_chk("rst_mask", MASK_ID, 8'h00);
        rd_chk("rst_pend", PEND_ID, 8'h00);
        rd_chk("rst_stat", STAT_ID, 8'h00);
        tick();
        RESET_N = 1'b1;
        tick();

        // Basic request/ack/return with exact synchroniser latency.
        io_write(MASK_ID, 8'h01);
        rd_chk("basic_mask", MASK_ID, 8'h01);
        pulse_set();
        chk("basic_iflag_set", {7'd0, I_FLAG}, 8'h01);
        INT_SRC[0] = 1'b1;
        exp_q.push_back(0);
        tick();
        rd_chk("basic_pend_e0", PEND_ID, 8'h00);
        tick();
        INT_SRC[0] = 1'b0;
        rd_chk("basic_pend_e1", PEND_ID, 8'h00);
        tick();
        rd_chk("basic_pend_e2", PEND_ID, 8'h01);
        chk("basic_noreq_e2", {7'd0, INT_REQ}, 8'h00);
        tick();
        chk("basic_req_e3", {7'd0, INT_REQ}, 8'h01);
        wait_req("basic");
        rd_chk("basic_stat_req", STAT_ID, 8'hA0);
        pulse_ack();
        chk("basic_ack_req",   {7'd0, INT_REQ}, 8'h00);
        chk("basic_ack_iflag", {7'd0, I_FLAG},  8'h00);
        rd_chk("basic_ack_pend", PEND_ID, 8'h00);
        rd_chk("basic_ack_stat", STAT_ID, 8'h40);
        pulse_set();
        rd_chk("basic_retie_stat", STAT_ID, 8'h80);

        // Priority: sources 3 and 1 together, 1 is granted first.
        io_write(MASK_ID, 8'h0F);
        exp_q.push_back(1);
        exp_q.push_back(3);
        src_pulse(4'b1010);
        wait_req("prio_first");
        rd_chk("prio_pend", PEND_ID, 8'h0A);
        pulse_ack();
        rd_chk("prio_pend_after_ack", PEND_ID, 8'h08);
        pulse_set();
        wait_req("prio_second");
        pulse_ack();
        pulse_set();
        tick();
        chk("prio_idle_req", {7'd0, INT_REQ}, 8'h00);

        // Masking: pending latches while masked; enabling the mask requests next edge.
        io_write(MASK_ID, 8'h00);
        src_pulse(4'b0100);
        tick(3);
        rd_chk("mask_pend", PEND_ID, 8'h04);
        chk("mask_noreq", {7'd0, INT_REQ}, 8'h00);
        exp_q.push_back(2);
        io_write(MASK_ID, 8'h04);
        chk("mask_req_wr_edge", {7'd0, INT_REQ}, 8'h00);
        tick();
        chk("mask_req_next", {7'd0, INT_REQ}, 8'h01);
        wait_req("mask");

        // Withdraw: clearing the pending bit drops the request; a late ack is ignored.
        io_write(PEND_ID, 8'h04);
        rd_chk("wd_pend", PEND_ID, 8'h00);
        chk("wd_req_still", {7'd0, INT_REQ}, 8'h01);
        tick();
        chk("wd_req_drop", {7'd0, INT_REQ}, 8'h00);
        rd_chk("wd_stat", STAT_ID, 8'h82);
        pulse_ack();
        chk("wd_ack_iflag", {7'd0, I_FLAG}, 8'h01);
        rd_chk("wd_ack_stat", STAT_ID, 8'h82);
        rd_chk("other_port", 8'h55, 8'h00);

        // Simultaneous edge and ack on source 0; the held level must not re-set pending.
        io_write(MASK_ID, 8'h01);
        exp_q.push_back(0);
        src_pulse(4'b0001);
        wait_req("sim_first");
        tick(3);
        INT_SRC[0] = 1'b1;
        tick(2);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        rd_chk("sim_pend", PEND_ID, 8'h01);
        chk("sim_req", {7'd0, INT_REQ}, 8'h00);
        rd_chk("sim_stat", STAT_ID, 8'h40);
        exp_q.push_back(0);
        pulse_set();
        wait_req("sim_rereq");
        pulse_ack();
        tick(3);
        rd_chk("sim_level_once", PEND_ID, 8'h00);
        INT_SRC[0] = 1'b0;
        pulse_set();

        // Asynchronous reset in the middle of a request.
        tick(3);
        exp_q.push_back(0);
        src_pulse(4'b0001);
        wait_req("rst_mid");
        #1;
        RESET_N = 1'b0;
        #1;
        chk("rstmid_req",   {7'd0, INT_REQ}, 8'h00);
        chk("rstmid_iflag", {7'd0, I_FLAG},  8'h00);
        rd_chk("rstmid_mask", MASK_ID, 8'h00);
        rd_chk("rstmid_pend", PEND_ID, 8'h00);

        chk("sb_empty", 8'(exp_q.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
